// File: rtl/mdu_ex.sv
// mdu_ex: E-stage multiply/divide unit with private HI/LO and fixed-latency busy sequencing
module mdu_ex #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  MDU_Op,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        busyOrStart,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAX_CYCLES = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [31:0] pending_hi, pending_lo;
  logic pending_ok;
  logic is_calc, is_mul, is_div, ovf;
  logic [31:0] b_safe, s_quo, s_rem, u_quo, u_rem;
  logic [63:0] s_prod, u_prod, res;
  assign is_calc = MDU_Op >= 3'd1 && MDU_Op <= 3'd4;
  assign is_mul = MDU_Op == 3'd1 || MDU_Op == 3'd2;
  assign is_div = MDU_Op == 3'd3 || MDU_Op == 3'd4;
  assign ovf = A == 32'h8000_0000 && B == 32'hFFFF_FFFF;
  assign b_safe = B == 32'd0 ? 32'd1 : B;
  assign s_prod = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
  assign u_prod = {32'd0, A} * {32'd0, B};
  assign s_quo = ovf ? 32'h8000_0000 : 32'($signed(A) / $signed(b_safe));
  assign s_rem = ovf ? 32'd0 : 32'($signed(A) % $signed(b_safe));
  assign u_quo = A / b_safe;
  assign u_rem = A % b_safe;
  assign res = MDU_Op == 3'd1 ? s_prod : MDU_Op == 3'd2 ? u_prod :
               MDU_Op == 3'd3 ? {s_rem, s_quo} : {u_rem, u_quo};
  assign busy = state == BUSY;
  assign busyOrStart = busy | (start & is_calc);
  // IDLE/BUSY sequencing: capture result on start, count down, commit on the last busy edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      HI <= '0;
      LO <= '0;
      pending_hi <= '0;
      pending_lo <= '0;
      pending_ok <= 1'b0;
    end else if (state == IDLE) begin
      if (start && is_calc) begin
        state <= BUSY;
        cnt <= is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1);
        pending_hi <= res[63:32];
        pending_lo <= res[31:0];
        pending_ok <= !(is_div && B == 32'd0);
      end else if (MDU_Op == 3'd5) begin
        HI <= A;
      end else if (MDU_Op == 3'd6) begin
        LO <= A;
      end
    end else if (cnt == '0) begin
      state <= IDLE;
      if (pending_ok) begin
        HI <= pending_hi;
        LO <= pending_lo;
      end
    end else begin
      cnt <= cnt - 1'b1;
    end
  end
endmodule

// File: tb/tb_mdu_ex.sv
// tb_mdu_ex: directed checks of mdu_ex arithmetic, busy timing, mt*, ignored ops and reset abort
module tb_mdu_ex;
  logic clk = 0, reset = 0, start = 0, busy, busyOrStart;
  logic [2:0] MDU_Op = 0;
  logic [31:0] A = 0, B = 0, HI, LO;
  int total = 0, bad = 0;
  mdu_ex dut (.clk(clk), .reset(reset), .MDU_Op(MDU_Op), .start(start), .A(A), .B(B),
              .busy(busy), .busyOrStart(busyOrStart), .HI(HI), .LO(LO));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic [31:0] eh,
                        input logic [31:0] el);
    MDU_Op = op; start = 1; A = a; B = b;
    #1;
    chk({tag, "_bos"}, 32'(busyOrStart), 1);
    chk({tag, "_pre_busy"}, 32'(busy), 0);
    tick();
    MDU_Op = 0; start = 0; A = 0; B = 0;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_busy%0d", tag, i), 32'(busy), 1);
      if (i < n - 1) tick();
    end
    tick();
    chk({tag, "_done"}, 32'(busy), 0);
    chk({tag, "_hi"}, HI, eh);
    chk({tag, "_lo"}, LO, el);
  endtask
  initial begin
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("rst_hi", HI, 0);
    chk("rst_lo", LO, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_bos", 32'(busyOrStart), 0);
    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    MDU_Op = 3'd5; A = 32'h1234_5678;
    #1;
    chk("mthi_bos", 32'(busyOrStart), 0);
    tick();
    chk("mthi_hi", HI, 32'h1234_5678);
    chk("mthi_lo", LO, 32'h8000_0000);
    chk("mthi_busy", 32'(busy), 0);
    MDU_Op = 3'd6; A = 32'h9ABC_DEF0;
    tick();
    chk("mtlo_lo", LO, 32'h9ABC_DEF0);
    chk("mtlo_hi", HI, 32'h1234_5678);
    chk("mtlo_busy", 32'(busy), 0);
    MDU_Op = 0; A = 0;
    run_op("div0", 3'd3, 32'd55, 32'd0, 10, 32'h1234_5678, 32'h9ABC_DEF0);
    MDU_Op = 3'd1; start = 1; A = 32'd5; B = 32'd6;
    tick();
    MDU_Op = 0; start = 0; A = 0; B = 0;
    tick();
    tick();
    MDU_Op = 3'd4; start = 1; A = 32'd9; B = 32'd4;
    tick();
    MDU_Op = 3'd5; start = 0; A = 32'hDEAD_BEEF;
    tick();
    MDU_Op = 0; A = 0; B = 0;
    chk("ign_busy4", 32'(busy), 1);
    chk("ign_hi_mid", HI, 32'h1234_5678);
    tick();
    chk("ign_done", 32'(busy), 0);
    chk("ign_hi", HI, 32'd0);
    chk("ign_lo", LO, 32'd30);
    tick();
    chk("ign_nostart", 32'(busy), 0);
    MDU_Op = 3'd3; start = 1; A = 32'd100; B = 32'd7;
    tick();
    MDU_Op = 0; start = 0; A = 0; B = 0;
    tick();
    tick();
    tick();
    chk("abort_busy4", 32'(busy), 1);
    reset = 1;
    tick();
    reset = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_hi", HI, 0);
    chk("abort_lo", LO, 0);
    for (int i = 0; i < 12; i++) tick();
    chk("abort_late_busy", 32'(busy), 0);
    chk("abort_late_hi", HI, 0);
    chk("abort_late_lo", LO, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
